// File: rtl/udp_rx_port_buffer.sv
// rtl/udp_rx_port_buffer.sv - single-port UDP RX datagram buffer with commit/rollback payload FIFO
// Optional statistics counters: define UDP_RX_BUF_STATS_EN.
module udp_rx_port_buffer #(
    parameter logic [15:0] PORT       = 16'd5000,
    parameter int          DATA_DEPTH = 512,
    parameter int          HDR_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_start,
    input  logic        rx_data_valid,
    input  logic [2:0]  rx_bytes_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_commit,
    input  logic        rx_drop,
    input  logic [15:0] rx_src_port,
    input  logic [15:0] rx_dst_port,
    input  logic [15:0] rx_payload_len,
    input  logic [31:0] rx_src_ip,
    output logic        pkt_ready,
    output logic [31:0] pkt_src_ip,
    output logic [15:0] pkt_src_port,
    output logic [15:0] pkt_len,
    input  logic        pkt_rd_en,
    output logic        pkt_data_valid,
    output logic [31:0] pkt_data,
    output logic [2:0]  pkt_bytes_valid,
    output logic        pkt_last
`ifdef UDP_RX_BUF_STATS_EN
    ,
    output logic [31:0] stat_commits,
    output logic [31:0] stat_drops,
    output logic [31:0] stat_overflows
`endif
);

    localparam int AW  = $clog2(DATA_DEPTH);
    localparam int PW  = AW + 1;
    localparam int HAW = $clog2(HDR_DEPTH);
    localparam int HPW = HAW + 1;
    localparam logic [PW-1:0]  DATA_FULL = PW'(DATA_DEPTH);
    localparam logic [HPW-1:0] HDR_FULL  = HPW'(HDR_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} wr_state_t;

    wr_state_t state, state_nxt;

    logic [PW-1:0] wr_ptr, wr_ptr_nxt, wr_start, wr_start_nxt;
    logic [PW-1:0] commit_ptr, commit_ptr_nxt, rd_ptr, base_ptr;
    logic [HPW-1:0] hwr_ptr, hrd_ptr;

    logic [34:0] ram [DATA_DEPTH];
    logic [34:0] ram_q;
    logic [63:0] hdr_mem [HDR_DEPTH];
    logic [63:0] hdr_head;

    logic [31:0] lat_ip;
    logic [15:0] lat_port, lat_len;

    logic data_full, hdr_full, hdr_empty;
    logic ram_we, hdr_push, hdr_latch;
    logic ev_drop, ev_reject, ev_ovf;

    logic        rd_go, rd_last, rd_ram_q;
    logic [15:0] rd_cnt, last_idx;

    assign data_full = (wr_ptr - rd_ptr) == DATA_FULL;
    assign hdr_full  = (hwr_ptr - hrd_ptr) == HDR_FULL;
    assign hdr_empty = hwr_ptr == hrd_ptr;

    // A new rx_start abandons whatever is in flight, so the base for the
    // new datagram is the rolled-back pointer when we were accepting.
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        wr_start_nxt   = wr_start;
        commit_ptr_nxt = commit_ptr;
        base_ptr       = (state == ACCEPT) ? wr_start : wr_ptr;
        ram_we         = 1'b0;
        hdr_push       = 1'b0;
        hdr_latch      = 1'b0;
        ev_drop        = 1'b0;
        ev_reject      = 1'b0;
        ev_ovf         = 1'b0;
        if (rx_start) begin
            wr_ptr_nxt = base_ptr;
            if (rx_dst_port == PORT && !hdr_full) begin
                state_nxt    = ACCEPT;
                hdr_latch    = 1'b1;
                wr_start_nxt = base_ptr;
            end else begin
                state_nxt = DISCARD;
                ev_reject = 1'b1;
            end
        end else begin
            case (state)
                ACCEPT: begin
                    if (rx_drop) begin
                        wr_ptr_nxt = wr_start;
                        state_nxt  = IDLE;
                        ev_drop    = 1'b1;
                    end else begin
                        if (rx_data_valid && rx_bytes_valid != 3'd0) begin
                            if (data_full) begin
                                wr_ptr_nxt = wr_start;
                                ev_ovf     = 1'b1;
                                state_nxt  = rx_commit ? IDLE : DISCARD;
                            end else begin
                                ram_we     = 1'b1;
                                wr_ptr_nxt = wr_ptr + PW'(1);
                            end
                        end
                        if (rx_commit && !ev_ovf) begin
                            commit_ptr_nxt = wr_ptr_nxt;
                            hdr_push       = 1'b1;
                            state_nxt      = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (rx_commit || rx_drop)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_start   <= '0;
            commit_ptr <= '0;
            hwr_ptr    <= '0;
            lat_ip     <= '0;
            lat_port   <= '0;
            lat_len    <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            wr_start   <= wr_start_nxt;
            commit_ptr <= commit_ptr_nxt;
            if (hdr_push)
                hwr_ptr <= hwr_ptr + HPW'(1);
            if (hdr_latch) begin
                lat_ip   <= rx_src_ip;
                lat_port <= rx_src_port;
                lat_len  <= rx_payload_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[wr_ptr[AW-1:0]] <= {rx_bytes_valid, rx_data};
        if (hdr_push)
            hdr_mem[hwr_ptr[HAW-1:0]] <= {lat_ip, lat_port, lat_len};
        ram_q <= ram[rd_ptr[AW-1:0]];
    end

    assign hdr_head     = hdr_mem[hrd_ptr[HAW-1:0]];
    assign pkt_ready    = !hdr_empty;
    assign pkt_src_ip   = pkt_ready ? hdr_head[63:32] : 32'd0;
    assign pkt_src_port = pkt_ready ? hdr_head[31:16] : 16'd0;
    assign pkt_len      = pkt_ready ? hdr_head[15:0]  : 16'd0;

    // Final word index is (len-1)/4; a zero-length datagram is a single empty beat.
    assign last_idx = (pkt_len - 16'd1) >> 2;
    assign rd_go    = pkt_rd_en && pkt_ready;
    assign rd_last  = (pkt_len == 16'd0) || (rd_cnt == last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr         <= '0;
            hrd_ptr        <= '0;
            rd_cnt         <= '0;
            rd_ram_q       <= 1'b0;
            pkt_data_valid <= 1'b0;
            pkt_last       <= 1'b0;
        end else begin
            pkt_data_valid <= rd_go;
            pkt_last       <= rd_go && rd_last;
            rd_ram_q       <= rd_go && (pkt_len != 16'd0);
            if (rd_go) begin
                if (pkt_len != 16'd0 && rd_ptr != commit_ptr)
                    rd_ptr <= rd_ptr + PW'(1);
                if (rd_last) begin
                    hrd_ptr <= hrd_ptr + HPW'(1);
                    rd_cnt  <= '0;
                end else begin
                    rd_cnt <= rd_cnt + 16'd1;
                end
            end
        end
    end

    assign pkt_data        = rd_ram_q ? ram_q[31:0]  : 32'd0;
    assign pkt_bytes_valid = rd_ram_q ? ram_q[34:32] : 3'd0;

`ifdef UDP_RX_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_commits   <= '0;
            stat_drops     <= '0;
            stat_overflows <= '0;
        end else begin
            if (hdr_push && stat_commits != '1)
                stat_commits <= stat_commits + 32'd1;
            if ((ev_drop || ev_reject) && stat_drops != '1)
                stat_drops <= stat_drops + 32'd1;
            if (ev_ovf && stat_overflows != '1)
                stat_overflows <= stat_overflows + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_rx_port_buffer.sv
// tb/tb_udp_rx_port_buffer.sv - scoreboard bench for udp_rx_port_buffer
module tb_udp_rx_port_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_start, rx_data_valid, rx_commit, rx_drop;
    logic [2:0]  rx_bytes_valid;
    logic [31:0] rx_data, rx_src_ip;
    logic [15:0] rx_src_port, rx_dst_port, rx_payload_len;
    logic        pkt_ready, pkt_rd_en, pkt_data_valid, pkt_last;
    logic [31:0] pkt_src_ip, pkt_data;
    logic [15:0] pkt_src_port, pkt_len;
    logic [2:0]  pkt_bytes_valid;
`ifdef UDP_RX_BUF_STATS_EN
    logic [31:0] stat_commits, stat_drops, stat_overflows;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bv;
        logic        last;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    udp_rx_port_buffer #(.PORT(16'd5000), .DATA_DEPTH(16), .HDR_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_bytes_valid(rx_bytes_valid),
        .rx_data(rx_data), .rx_commit(rx_commit), .rx_drop(rx_drop),
        .rx_src_port(rx_src_port), .rx_dst_port(rx_dst_port),
        .rx_payload_len(rx_payload_len), .rx_src_ip(rx_src_ip),
        .pkt_ready(pkt_ready), .pkt_src_ip(pkt_src_ip), .pkt_src_port(pkt_src_port),
        .pkt_len(pkt_len), .pkt_rd_en(pkt_rd_en), .pkt_data_valid(pkt_data_valid),
        .pkt_data(pkt_data), .pkt_bytes_valid(pkt_bytes_valid), .pkt_last(pkt_last)
`ifdef UDP_RX_BUF_STATS_EN
        , .stat_commits(stat_commits), .stat_drops(stat_drops), .stat_overflows(stat_overflows)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dg(input logic [15:0] port, input logic [15:0] len);
        rx_start = 1'b1; rx_dst_port = port; rx_payload_len = len;
        rx_src_ip = 32'h0A000001; rx_src_port = 16'd1234;
        tick();
        rx_start = 1'b0;
    endtask

    task automatic word(input logic [31:0] d, input logic [2:0] bv);
        rx_data_valid = 1'b1; rx_data = d; rx_bytes_valid = bv;
        tick();
        rx_data_valid = 1'b0; rx_bytes_valid = 3'd0;
    endtask

    task automatic finish_dg(input logic c, input logic d);
        rx_commit = c; rx_drop = d;
        tick();
        rx_commit = 1'b0; rx_drop = 1'b0;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic [2:0] bv, input logic last);
        beat_t b;
        b.data = d; b.bv = bv; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) begin
            pkt_rd_en = 1'b1;
            tick();
        end
        pkt_rd_en = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every output beat is matched against the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && pkt_data_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", pkt_data, b.data);
                chk("beat_bytes", {29'd0, pkt_bytes_valid}, {29'd0, b.bv});
                chk("beat_last", {31'd0, pkt_last}, {31'd0, b.last});
            end
        end
    end

    initial begin
        rst_n = 1'b0; rx_start = 0; rx_data_valid = 0; rx_commit = 0; rx_drop = 0;
        rx_bytes_valid = 0; rx_data = 0; rx_src_ip = 0; rx_src_port = 0;
        rx_dst_port = 0; rx_payload_len = 0; pkt_rd_en = 0;
        repeat (3) tick();
        chk("rst_ready", {31'd0, pkt_ready}, 32'd0);
        chk("rst_valid", {31'd0, pkt_data_valid}, 32'd0);
        chk("rst_last", {31'd0, pkt_last}, 32'd0);
        chk("rst_data", pkt_data, 32'd0);
        chk("rst_len", {16'd0, pkt_len}, 32'd0);
        chk("rst_ip", pkt_src_ip, 32'd0);
        rst_n = 1'b1;
        tick();

        // basic datagram, 10 bytes
        start_dg(16'd5000, 16'd10);
        word(32'hAABBCCDD, 3'd4);
        word(32'h11223344, 3'd4);
        word(32'h55660000, 3'd2);
        finish_dg(1'b1, 1'b0);
        expect_beat(32'hAABBCCDD, 3'd4, 1'b0);
        expect_beat(32'h11223344, 3'd4, 1'b0);
        expect_beat(32'h55660000, 3'd2, 1'b1);
        chk("t1_ready", {31'd0, pkt_ready}, 32'd1);
        chk("t1_len", {16'd0, pkt_len}, 32'd10);
        chk("t1_ip", pkt_src_ip, 32'h0A000001);
        chk("t1_sport", {16'd0, pkt_src_port}, 32'd1234);
        read_n(3);
        chk("t1_ready_after", {31'd0, pkt_ready}, 32'd0);

        // wrong port
        start_dg(16'd5001, 16'd8);
        word(32'h01010101, 3'd4);
        word(32'h02020202, 3'd4);
        finish_dg(1'b1, 1'b0);
        chk("t2_ready", {31'd0, pkt_ready}, 32'd0);
`ifdef UDP_RX_BUF_STATS_EN
        chk("t2_stat_drops", stat_drops, 32'd1);
`endif

        // drop then rollback proof
        start_dg(16'd5000, 16'd8);
        word(32'hDEAD0001, 3'd4);
        word(32'hDEAD0002, 3'd4);
        finish_dg(1'b0, 1'b1);
        chk("t3_ready_drop", {31'd0, pkt_ready}, 32'd0);
        start_dg(16'd5000, 16'd4);
        word(32'hCAFEF00D, 3'd4);
        finish_dg(1'b1, 1'b0);
        expect_beat(32'hCAFEF00D, 3'd4, 1'b1);
        chk("t3_len", {16'd0, pkt_len}, 32'd4);
        read_n(1);

        // overflow: 12 committed words, then 6-word datagram into 4 free slots
        start_dg(16'd5000, 16'd48);
        for (int i = 0; i < 12; i++) begin
            word(32'h10000000 + i, 3'd4);
            expect_beat(32'h10000000 + i, 3'd4, i == 11);
        end
        finish_dg(1'b1, 1'b0);
        start_dg(16'd5000, 16'd24);
        for (int i = 0; i < 6; i++) word(32'h20000000 + i, 3'd4);
        finish_dg(1'b1, 1'b0);
        chk("t4_len", {16'd0, pkt_len}, 32'd48);
`ifdef UDP_RX_BUF_STATS_EN
        chk("t4_stat_ovf", stat_overflows, 32'd1);
`endif
        read_n(12);
        chk("t4_ready_after", {31'd0, pkt_ready}, 32'd0);

        // commit and drop together, then zero-length datagram
        start_dg(16'd5000, 16'd4);
        word(32'h33333333, 3'd4);
        finish_dg(1'b1, 1'b1);
        chk("t5_ready_cd", {31'd0, pkt_ready}, 32'd0);
        start_dg(16'd5000, 16'd0);
        finish_dg(1'b1, 1'b0);
        expect_beat(32'd0, 3'd0, 1'b1);
        chk("t5_ready_zero", {31'd0, pkt_ready}, 32'd1);
        read_n(1);
        chk("t5_ready_after", {31'd0, pkt_ready}, 32'd0);

        // reset with two committed datagrams and one in flight
        start_dg(16'd5000, 16'd4); word(32'h44444444, 3'd4); finish_dg(1'b1, 1'b0);
        start_dg(16'd5000, 16'd4); word(32'h55555555, 3'd4); finish_dg(1'b1, 1'b0);
        start_dg(16'd5000, 16'd4); word(32'h66666666, 3'd4);
        rst_n = 1'b0;
        tick();
        chk("t6_ready", {31'd0, pkt_ready}, 32'd0);
        chk("t6_valid", {31'd0, pkt_data_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        start_dg(16'd5000, 16'd3);
        word(32'h77777700, 3'd3);
        finish_dg(1'b1, 1'b0);
        expect_beat(32'h77777700, 3'd3, 1'b1);
        chk("t6_len", {16'd0, pkt_len}, 32'd3);
        read_n(1);

        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
